pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_entry.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the inter-stage pipeline register.
//   state_e       - occupancy state of the two-entry stage (EMPTY/ONE/FULL)
//   BUBBLE_CNT_W  - width of the downstream bubble counter
//   CTRL_NOP_DEF  - default all-zero control word for an empty stage
//   sat_inc()     - saturating increment for the bubble counter
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int BUBBLE_CNT_W = 16;
  localparam int NCTRL_DEF    = 16;
  localparam logic [NCTRL_DEF-1:0] CTRL_NOP_DEF = '0;

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one storage slot (valid + ctrl + data) of a pipeline stage.
//   i_clk, i_rst  - clock, synchronous active-high reset (clears all fields)
//   i_clr         - synchronous clear of valid only; ctrl/data are kept
//   i_load        - capture i_valid/i_ctrl/i_data (i_clr wins if both set)
//   o_valid, o_ctrl, o_data - registered slot contents
module pipe_entry #(
  parameter int NCTRL = 16,
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [NCTRL-1:0] i_ctrl,
  input  logic [NBITS-1:0] i_data,
  output logic             o_valid,
  output logic [NCTRL-1:0] o_ctrl,
  output logic [NBITS-1:0] o_data
);

  logic             valid_q, valid_d;
  logic [NCTRL-1:0] ctrl_q, ctrl_d;
  logic [NBITS-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (i_clr) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      valid_d = i_valid;
      ctrl_d  = i_ctrl;
      data_d  = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_ctrl  = ctrl_q;
  assign o_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register with a 2-entry skid
// buffer, hazard stall/flush and NOP injection on the control word.
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_valid/o_ready     - upstream handshake (o_ready is a flop output)
//   i_ctrl, i_data      - upstream control and data words
//   i_stall             - freeze output (no take); input still accepted
//   i_flush             - drop everything held and incoming
//   o_valid/i_ready     - downstream handshake
//   o_ctrl, o_data      - head instruction; o_ctrl is CTRL_NOP when invalid
//   o_bubble_cnt        - saturating count of bubbles issued downstream
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               NBITS    = 32,
  parameter int               NCTRL    = 16,
  parameter logic [NCTRL-1:0] CTRL_NOP = {NCTRL{1'b0}}
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NCTRL-1:0]        i_ctrl,
  input  logic [NBITS-1:0]        i_data,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NCTRL-1:0]        o_ctrl,
  output logic [NBITS-1:0]        o_data,
  output logic [BUBBLE_CNT_W-1:0] o_bubble_cnt
);

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;

  logic             main_vld, skid_vld;
  logic [NCTRL-1:0] main_ctrl, skid_ctrl;
  logic [NBITS-1:0] main_data, skid_data;

  logic             main_load, main_clr, main_from_skid;
  logic             skid_load, skid_clr;
  logic             accept, take;

  // Main is refilled either from the upstream port or, when draining FULL,
  // from the skid slot so that the older instruction always leaves first.
  logic             main_in_vld;
  logic [NCTRL-1:0] main_in_ctrl;
  logic [NBITS-1:0] main_in_data;

  assign accept = i_valid & ready_q & ~i_flush;
  assign take   = main_vld & i_ready & ~i_stall;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (i_flush) begin
      // A take in this cycle still completes downstream; only storage drops.
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (take) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_in_vld  = main_from_skid ? skid_vld  : 1'b1;
    main_in_ctrl = main_from_skid ? skid_ctrl : i_ctrl;
    main_in_data = main_from_skid ? skid_data : i_data;
  end

  // Registered ready: low exactly while the skid slot is occupied.
  always_comb begin
    ready_d = (state_d != ST_FULL);
    cnt_d   = cnt_q;
    if (i_ready && !i_stall && !main_vld) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  pipe_entry #(.NCTRL(NCTRL), .NBITS(NBITS)) u_main (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (main_clr),
    .i_load  (main_load),
    .i_valid (main_in_vld),
    .i_ctrl  (main_in_ctrl),
    .i_data  (main_in_data),
    .o_valid (main_vld),
    .o_ctrl  (main_ctrl),
    .o_data  (main_data)
  );

  pipe_entry #(.NCTRL(NCTRL), .NBITS(NBITS)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (skid_clr),
    .i_load  (skid_load),
    .i_valid (1'b1),
    .i_ctrl  (i_ctrl),
    .i_data  (i_data),
    .o_valid (skid_vld),
    .o_ctrl  (skid_ctrl),
    .o_data  (skid_data)
  );

  assign o_valid      = main_vld;
  assign o_ready      = ready_q;
  assign o_ctrl       = main_vld ? main_ctrl : CTRL_NOP;
  assign o_data       = main_data;
  assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: FIFO-queue reference model updated on posedge,
// compared against the DUT on every negedge, plus hand-computed checkpoints.
module tb_pipe_stage_reg;
  localparam int NB = 32;
  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, o_ready, i_stall, i_flush, o_valid, i_ready;
  logic [NC-1:0] i_ctrl, o_ctrl;
  logic [NB-1:0] i_data, o_data;
  logic [15:0]   o_bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.NBITS(NB), .NCTRL(NC)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_ctrl       (i_ctrl),
    .i_data       (i_data),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_ctrl       (o_ctrl),
    .o_data       (o_data),
    .o_bubble_cnt (o_bubble_cnt)
  );

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  function automatic logic [NC-1:0] ctrl_of(input logic [NB-1:0] d);
    return {d[7:0], 8'hC3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the stage is a FIFO of depth 2.
  logic [NB-1:0] m_q[$];
  logic [NB-1:0] log_q[$];
  logic [NB-1:0] m_last;
  int            m_cnt;

  always @(posedge clk) begin : model_upd
    bit vo, rdy, tk, acc;
    if (rst) begin
      m_q.delete();
      m_cnt  = 0;
      m_last = '0;
    end else begin
      vo  = m_q.size() > 0;
      rdy = m_q.size() < 2;
      tk  = vo && i_ready && !i_stall;
      acc = i_valid && rdy && !i_flush;
      if (!vo && i_ready && !i_stall && m_cnt < 65535) m_cnt++;
      if (tk) begin
        log_q.push_back(m_q[0]);
        void'(m_q.pop_front());
      end
      if (i_flush) m_q.delete();
      else if (acc) m_q.push_back(i_data);
      if (m_q.size() > 0) m_last = m_q[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_valid", o_valid, m_q.size() > 0);
      chk("o_ready", o_ready, m_q.size() < 2);
      chk("o_ctrl", o_ctrl, (m_q.size() > 0) ? ctrl_of(m_q[0]) : 16'h0);
      chk("o_data", o_data, m_last);
      chk("o_bubble_cnt", o_bubble_cnt, m_cnt);
    end
  end

  task automatic step(input bit v, input logic [NB-1:0] d, input bit rdy,
                      input bit stl, input bit fl);
    i_valid = v;
    i_data  = d;
    i_ctrl  = ctrl_of(d);
    i_ready = rdy;
    i_stall = stl;
    i_flush = fl;
    @(negedge clk);
  endtask

  // Upstream source sending 1..n, holding each word until accepted.
  task automatic src_run(input int n, input int cycles, input int rlo, input int rhi,
                         input int slo, input int shi, input int ck,
                         input logic [NB-1:0] ck_data, input bit ck_rdy);
    int nxt = 1;
    for (int k = 1; k <= cycles; k++) begin
      bit v, rdy_now;
      v       = (nxt <= n);
      rdy_now = o_ready;
      step(v, nxt, !(k >= rlo && k <= rhi), (k >= slo && k <= shi), 1'b0);
      if (v && rdy_now) nxt++;
      if (k == ck) begin
        chk("mid_data", o_data, ck_data);
        chk("mid_ready", o_ready, ck_rdy);
      end
    end
  endtask

  task automatic check_log(input int n);
    chk("log_len", log_q.size(), n);
    for (int i = 0; i < n; i++) chk("log_item", log_q[i], i + 1);
  endtask

  initial begin
    rst = 1'b1;
    step(1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_data", o_data, 32'h0);
    rst = 1'b0;

    // Streaming at full rate
    src_run(8, 10, 0, -1, 0, -1, 8, 32'h8, 1'b1);
    chk("stream_bubbles", o_bubble_cnt, 16'd2);
    check_log(8);
    log_q.delete();

    // Back-pressure: downstream not ready in cycles 3..5
    src_run(6, 12, 3, 5, 0, -1, 3, 32'h2, 1'b0);
    check_log(6);
    log_q.delete();

    // Stall for cycles 3..4
    src_run(6, 12, 0, -1, 3, 4, 4, 32'h2, 1'b0);
    check_log(6);
    log_q.delete();

    // Flush in FULL with an incoming word
    step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    chk("full_ready", o_ready, 1'b0);
    step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1);
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_ctrl", o_ctrl, 16'h0);
    chk("flush_ready", o_ready, 1'b1);
    chk("flush_data_kept", o_data, 32'h11);
    // Flush in ONE while ready: incoming word dropped
    step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1);
    chk("flush1_valid", o_valid, 1'b0);
    chk("flush1_data", o_data, 32'h33);
    // Flush together with a take: head still delivered
    step(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("flush_take_valid", o_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_take_len", log_q.size(), 1);
    chk("flush_take_item", log_q[0], 32'h88);
    log_q.delete();

    // Bubble counter saturation, then reset
    repeat (70000) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("bubble_sat", o_bubble_cnt, 16'hFFFF);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("bubble_rst", o_bubble_cnt, 16'h0);

    // Reset while FULL, input during reset discarded
    step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rstfull_valid", o_valid, 1'b0);
    chk("rstfull_ready", o_ready, 1'b1);
    chk("rstfull_cnt", o_bubble_cnt, 16'h0);
    chk("rstfull_data", o_data, 32'h0);
    step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    chk("post_rst_valid", o_valid, 1'b1);
    chk("post_rst_data", o_data, 32'h77);
    chk("post_rst_ctrl", o_ctrl, 16'h77C3);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_log_len", log_q.size(), 1);
    chk("post_rst_log", log_q[0], 32'h77);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
